// File: rtl/mgr_mrc_pkg.sv
// Shared definitions for the manager read controller: field widths,
// stream framing codes, controller states and the framing rule.
package mgr_mrc_pkg;

  // Address and length field widths shared with mwc_cntl and the mmc
  localparam int MGR_CHAN_W = 1;
  localparam int MGR_BANK_W = 3;
  localparam int MGR_PAGE_W = 15;
  localparam int MGR_WORD_W = 7;
  localparam int MGR_LEN_W  = 8;

  // Stream framing codes on the return path
  localparam logic [1:0] CNTL_MOM     = 2'b00;
  localparam logic [1:0] CNTL_SOM     = 2'b01;
  localparam logic [1:0] CNTL_EOM     = 2'b10;
  localparam logic [1:0] CNTL_SOM_EOM = 2'b11;

  // Read controller states
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  // Framing code for line number idx of a message that is len lines long
  function automatic logic [1:0] frame_cntl(input int unsigned idx, input int unsigned len);
    logic [1:0] code;
    if (len == 32'd1) begin
      code = CNTL_SOM_EOM;
    end else if (idx == 32'd0) begin
      code = CNTL_SOM;
    end else if (idx == len - 32'd1) begin
      code = CNTL_EOM;
    end else begin
      code = CNTL_MOM;
    end
    return code;
  endfunction

endpackage

// File: rtl/mrc_resp_fifo.sv
// First-word-fall-through response buffer. The head entry is always
// presented on pop_data; push is ignored when full, pop when empty.
module mrc_resp_fifo #(
  parameter int DATA_W = 256,
  parameter int DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [DATA_W-1:0]        push_data,
  input  logic                     pop,
  output logic [DATA_W-1:0]        pop_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == {(AW+1){1'b0}});
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign pop_data = mem[rd_ptr];

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= {AW{1'b0}};
      rd_ptr <= {AW{1'b0}};
      count  <= {(AW+1){1'b0}};
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // Line storage; contents are only observed through valid entries
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/mrc_cntl.sv
// Main-memory read controller: takes one read descriptor, issues
// single-line reads to the mmc under credit control, buffers the returned
// lines and streams them downstream with SOM/MOM/EOM framing.
module mrc_cntl
  import mgr_mrc_pkg::*;
#(
  parameter int CHAN_W     = MGR_CHAN_W,
  parameter int BANK_W     = MGR_BANK_W,
  parameter int PAGE_W     = MGR_PAGE_W,
  parameter int WORD_W     = MGR_WORD_W,
  parameter int LEN_W      = MGR_LEN_W,
  parameter int DATA_W     = 256,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              reset_poweron,
  input  logic              req__mrc__valid,
  output logic              mrc__req__ready,
  input  logic [CHAN_W-1:0] req__mrc__channel,
  input  logic [BANK_W-1:0] req__mrc__bank,
  input  logic [PAGE_W-1:0] req__mrc__page,
  input  logic [WORD_W-1:0] req__mrc__word,
  input  logic [LEN_W-1:0]  req__mrc__num_lines,
  output logic              mrc__mmc__valid,
  input  logic              mmc__mrc__ready,
  output logic [CHAN_W-1:0] mrc__mmc__channel,
  output logic [BANK_W-1:0] mrc__mmc__bank,
  output logic [PAGE_W-1:0] mrc__mmc__page,
  output logic [WORD_W-1:0] mrc__mmc__word,
  input  logic              mmc__mrc__valid,
  input  logic [DATA_W-1:0] mmc__mrc__data,
  output logic              mrc__dst__valid,
  output logic [1:0]        mrc__dst__cntl,
  output logic [DATA_W-1:0] mrc__dst__data,
  input  logic              dst__mrc__ready,
  output logic              mrc__err
);

  localparam int LW = LEN_W + 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [1:0]        state, state_nxt;
  logic [LW-1:0]     len, len_nxt, req_len;
  logic [LW-1:0]     issue_cnt, issue_cnt_nxt, out_cnt;
  logic [CW-1:0]     outstanding, outstanding_nxt, count_nxt;
  logic [CW:0]       credit_sum;
  logic              cmd_valid, cmd_valid_nxt, req_ready, err;
  logic              accept, cmd_hs, out_hs, resp_ok, push, drop;
  logic [CW-1:0]     fifo_count;
  logic              fifo_full, fifo_empty;
  logic [DATA_W-1:0] fifo_data;

  mrc_resp_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (reset_poweron),
    .push      (push),
    .push_data (mmc__mrc__data),
    .pop       (out_hs),
    .pop_data  (fifo_data),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Handshakes, credit accounting and next-state decode
  always_comb begin
    req_len       = (req__mrc__num_lines == {LEN_W{1'b0}}) ? LW'(1) : {1'b0, req__mrc__num_lines};
    accept        = req__mrc__valid & req_ready;
    cmd_hs        = cmd_valid & mmc__mrc__ready;
    out_hs        = ~fifo_empty & dst__mrc__ready;
    resp_ok       = mmc__mrc__valid & (outstanding != {CW{1'b0}});
    push          = resp_ok & ~fifo_full;
    drop          = mmc__mrc__valid & ~push;
    state_nxt     = state;
    len_nxt       = len;
    issue_cnt_nxt = issue_cnt;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_nxt     = ST_ISSUE;
          len_nxt       = req_len;
          issue_cnt_nxt = {LW{1'b0}};
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (cmd_hs) begin
          issue_cnt_nxt = issue_cnt + LW'(1);
          state_nxt     = (issue_cnt_nxt == len) ? ST_DRAIN : ST_ISSUE;
        end else begin
          state_nxt = ST_ISSUE;
        end
      end
      ST_DRAIN: begin
        if (out_hs && (out_cnt + LW'(1) == len)) begin
          state_nxt = ST_IDLE;
        end else begin
          state_nxt = ST_DRAIN;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    // Lines in flight plus lines buffered must leave room for one more
    outstanding_nxt = outstanding + CW'(cmd_hs) - CW'(resp_ok);
    count_nxt       = fifo_count + CW'(push) - CW'(out_hs);
    credit_sum      = {1'b0, outstanding_nxt} + {1'b0, count_nxt};
    cmd_valid_nxt   = (state_nxt == ST_ISSUE) && (issue_cnt_nxt < len_nxt) &&
                      (credit_sum < (CW+1)'(FIFO_DEPTH));
  end

  // Control state, counters, registered handshake outputs and sticky error
  always_ff @(posedge clk or posedge reset_poweron) begin
    if (reset_poweron) begin
      state       <= ST_IDLE;
      len         <= {LW{1'b0}};
      issue_cnt   <= {LW{1'b0}};
      out_cnt     <= {LW{1'b0}};
      outstanding <= {CW{1'b0}};
      cmd_valid   <= 1'b0;
      req_ready   <= 1'b1;
      err         <= 1'b0;
    end else begin
      state       <= state_nxt;
      len         <= len_nxt;
      issue_cnt   <= issue_cnt_nxt;
      outstanding <= outstanding_nxt;
      cmd_valid   <= cmd_valid_nxt;
      req_ready   <= (state_nxt == ST_IDLE);
      err         <= err | drop;
      if (accept) begin
        out_cnt <= {LW{1'b0}};
      end else if (out_hs) begin
        out_cnt <= out_cnt + LW'(1);
      end
    end
  end

  // Command address: latched on accept, advanced after each accepted command
  always_ff @(posedge clk or posedge reset_poweron) begin
    if (reset_poweron) begin
      mrc__mmc__channel <= {CHAN_W{1'b0}};
      mrc__mmc__bank    <= {BANK_W{1'b0}};
      mrc__mmc__page    <= {PAGE_W{1'b0}};
      mrc__mmc__word    <= {WORD_W{1'b0}};
    end else if (accept) begin
      mrc__mmc__channel <= req__mrc__channel;
      mrc__mmc__bank    <= req__mrc__bank;
      mrc__mmc__page    <= req__mrc__page;
      mrc__mmc__word    <= req__mrc__word;
    end else if (cmd_hs) begin
      mrc__mmc__word <= mrc__mmc__word + WORD_W'(1);
      if (mrc__mmc__word == {WORD_W{1'b1}}) begin
        mrc__mmc__page <= mrc__mmc__page + PAGE_W'(1);
      end
    end
  end

  assign mrc__req__ready = req_ready;
  assign mrc__mmc__valid = cmd_valid;
  assign mrc__err        = err;
  assign mrc__dst__valid = ~fifo_empty;
  assign mrc__dst__cntl  = fifo_empty ? CNTL_MOM : frame_cntl(32'(out_cnt), 32'(len));
  assign mrc__dst__data  = fifo_empty ? {DATA_W{1'b0}} : fifo_data;

endmodule
